jar_pi_streamer: RTL and testbench

- Parametrised successor to the fixed 1000-digit pi display block. Streams digits from an external digit ROM (pi table or any BCD table), one digit at a time, to a seven-segment decoder.
- Adds the following, none of which the fixed block has:
  - run/stop control;
  - single-step;
  - serial index load;
  - configurable table length;
  - configurable per-digit hold time and a blank gap, so that repeated digits stay visible;
  - a wrap flag.
- Sits between the io_in pin bus and the shared segment decoder in the TinyTapeout slot.

---
 rtl/jar_pi_streamer.sv | 141 ++++++++++++++
 tb/tb_jar_pi_streamer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jar_pi_streamer.sv
// jar_pi_streamer: walks an index through an external BCD digit ROM and presents each digit
// for HOLD cycles, then GAP blank cycles. Define JAR_PI_DP_MARK_EN to light dp on index 0.
module jar_pi_streamer #(
  parameter int INDEX_W = 10,
  parameter int DIGITS  = 1000,
  parameter int LOAD_W  = 5,
  parameter int HOLD    = 4,
  parameter int GAP     = 1,
  parameter int ROM_LAT = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stream,
  input  logic               step,
  input  logic               load,
  input  logic [LOAD_W-1:0]  load_data,
  output logic [INDEX_W-1:0] rom_addr,
  input  logic [3:0]         rom_data,
  output logic [3:0]         digit,
  output logic               digit_valid,
  output logic               wrap,
  output logic               dp
);

  // state    | meaning
  // ST_IDLE  | waiting; load shifts the index, stream/step start a digit
  // ST_FETCH | ROM_LAT+1 cycles with rom_addr stable, digit captured on the last one
  // ST_SHOW  | digit presented with digit_valid for HOLD cycles
  // ST_GAP   | blank code for GAP cycles so repeated digits stay distinguishable
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SHOW, ST_GAP} state_t;

  localparam int FETCH_N = ROM_LAT;
  localparam int HOLD_N  = (HOLD > 0) ? HOLD - 1 : 0;
  localparam int GAP_N   = (GAP > 0) ? GAP - 1 : 0;
  localparam int MAX_A   = (FETCH_N > HOLD_N) ? FETCH_N : HOLD_N;
  localparam int CNT_MAX = (MAX_A > GAP_N) ? MAX_A : GAP_N;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   FETCH_LD = CNT_W'(FETCH_N);
  localparam logic [CNT_W-1:0]   HOLD_LD  = CNT_W'(HOLD_N);
  localparam logic [CNT_W-1:0]   GAP_LD   = CNT_W'(GAP_N);
  localparam logic [INDEX_W:0]   DIGITS_X = (INDEX_W + 1)'(DIGITS);
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DIGITS - 1);
  localparam logic [3:0]         BLANK    = 4'hF;

  state_t             state;
  logic [INDEX_W-1:0] index;
  logic [CNT_W-1:0]   cnt;

  assign rom_addr = index;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      index       <= '0;
      cnt         <= '0;
      digit       <= BLANK;
      digit_valid <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            index <= {load_data, index[INDEX_W-1:LOAD_W]};
          end else if (stream || step) begin
            state <= ST_FETCH;
            cnt   <= FETCH_LD;
            if ({1'b0, index} >= DIGITS_X) index <= '0;
          end
        end
        ST_FETCH: begin
          if (cnt == '0) begin
            digit       <= rom_data;
            digit_valid <= 1'b1;
            state       <= ST_SHOW;
            cnt         <= HOLD_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == '0) begin
            digit       <= BLANK;
            digit_valid <= 1'b0;
            if (index == LAST_IDX) begin
              index <= '0;
              wrap  <= 1'b1;
            end else begin
              index <= index + 1'b1;
            end
            if (GAP > 0) begin
              state <= ST_GAP;
              cnt   <= GAP_LD;
            end else if (stream) begin
              state <= ST_FETCH;
              cnt   <= FETCH_LD;
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            if (stream) begin
              state <= ST_FETCH;
              cnt   <= FETCH_LD;
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JAR_PI_DP_MARK_EN
  // dp tracks the index captured with the digit, so it stays put while the index advances
  logic dp_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dp_q <= 1'b0;
    end else if (state == ST_FETCH && cnt == '0) begin
      dp_q <= (index == '0);
    end else if (state == ST_SHOW && cnt == '0) begin
      dp_q <= 1'b0;
    end
  end
  assign dp = dp_q;
`else
  assign dp = 1'b0;
`endif

endmodule

// File: tb/tb_jar_pi_streamer.sv
// Directed bench for jar_pi_streamer with a combinational digit ROM (leading pi digits,
// then index mod 10 as filler so table positions 998/999 read back as 8/9).
module tb_jar_pi_streamer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       stream = 1'b0;
  logic       step = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_data = '0;
  logic [9:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] digit;
  logic       digit_valid;
  logic       wrap;
  logic       dp;

  int checks = 0;
  int errors = 0;

`ifdef JAR_PI_DP_MARK_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  jar_pi_streamer dut (
    .clk(clk), .reset_n(reset_n), .stream(stream), .step(step), .load(load),
    .load_data(load_data), .rom_addr(rom_addr), .rom_data(rom_data),
    .digit(digit), .digit_valid(digit_valid), .wrap(wrap), .dp(dp)
  );

  function automatic logic [3:0] rom_model(input logic [9:0] a);
    logic [3:0] pi_lead [0:9];
    pi_lead = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd5, 4'd3};
    if (a < 10) return pi_lead[a];
    return 4'(a % 10);
  endfunction

  assign rom_data = rom_model(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stream = 1'b0; step = 1'b0; load = 1'b0; load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (digit !== 4'hF || digit_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: digit=%h valid=%b, expected F/0", digit, digit_valid);
    end
    checks++;
    if (wrap !== 1'b0 || dp !== 1'b0 || rom_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_misc: wrap=%b dp=%b addr=%0d, expected 0/0/0", wrap, dp, rom_addr);
    end
  endtask

  task automatic test_stream();
    logic       ev;
    logic [3:0] ed;
    logic [9:0] ea;
    do_reset();
    stream = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      ev = (c >= 2 && c <= 5) || (c >= 8 && c <= 11) || (c >= 14 && c <= 17);
      ed = !ev ? 4'hF : (c <= 5) ? 4'd3 : (c <= 11) ? 4'd1 : 4'd4;
      ea = (c <= 5) ? 10'd0 : (c <= 11) ? 10'd1 : 10'd2;
      checks++;
      if (digit !== ed || digit_valid !== ev) begin
        errors++;
        $display("FAIL stream_c%0d: digit=%h valid=%b, expected %h/%b", c, digit, digit_valid, ed, ev);
      end
      checks++;
      if (rom_addr !== ea) begin
        errors++;
        $display("FAIL stream_addr_c%0d: addr=%0d, expected %0d", c, rom_addr, ea);
      end
      checks++;
      if (dp !== (DP_EN && c >= 2 && c <= 5)) begin
        errors++;
        $display("FAIL stream_dp_c%0d: dp=%b, expected %b", c, dp, DP_EN && c >= 2 && c <= 5);
      end
    end
    stream = 1'b0;
    repeat (3) tick();
    checks++;
    if (rom_addr !== 10'd3 || digit_valid !== 1'b0 || digit !== 4'hF) begin
      errors++;
      $display("FAIL stream_stop: addr=%0d valid=%b digit=%h, expected 3/0/F", rom_addr, digit_valid, digit);
    end
    repeat (3) tick();
    checks++;
    if (rom_addr !== 10'd3) begin
      errors++;
      $display("FAIL stream_idle_hold: addr=%0d, expected 3", rom_addr);
    end
  endtask

  task automatic test_step();
    int         nvalid;
    logic [3:0] seen;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      nvalid = 0;
      seen = 4'hF;
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (digit_valid) begin
          nvalid++;
          seen = digit;
        end
        tick();
      end
      checks++;
      if (nvalid != 4) begin
        errors++;
        $display("FAIL step%0d_len: valid cycles=%0d, expected 4", k, nvalid);
      end
      checks++;
      if (seen !== ((k == 0) ? 4'd3 : 4'd1)) begin
        errors++;
        $display("FAIL step%0d_digit: digit=%h, expected %h", k, seen, (k == 0) ? 4'd3 : 4'd1);
      end
      checks++;
      if (rom_addr !== 10'(k + 1) || digit_valid !== 1'b0) begin
        errors++;
        $display("FAIL step%0d_after: addr=%0d valid=%b, expected %0d/0", k, rom_addr, digit_valid, k + 1);
      end
    end
  endtask

  task automatic test_wrap();
    int nwrap;
    do_reset();
    load = 1'b1; load_data = 5'b00110;
    tick();
    load_data = 5'b11111;
    tick();
    load = 1'b0;
    checks++;
    if (rom_addr !== 10'd998) begin
      errors++;
      $display("FAIL wrap_load: addr=%0d, expected 998", rom_addr);
    end
    stream = 1'b1;
    nwrap = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (wrap) nwrap++;
      if (c == 2) begin
        checks++;
        if (digit !== 4'd8 || digit_valid !== 1'b1) begin
          errors++;
          $display("FAIL wrap_d998: digit=%h valid=%b, expected 8/1", digit, digit_valid);
        end
      end
      if (c == 8) begin
        checks++;
        if (digit !== 4'd9 || rom_addr !== 10'd999) begin
          errors++;
          $display("FAIL wrap_d999: digit=%h addr=%0d, expected 9/999", digit, rom_addr);
        end
      end
      if (c == 12) begin
        checks++;
        if (wrap !== 1'b1 || rom_addr !== 10'd0) begin
          errors++;
          $display("FAIL wrap_pulse: wrap=%b addr=%0d, expected 1/0", wrap, rom_addr);
        end
      end
      if (c == 14) begin
        checks++;
        if (digit !== 4'd3 || digit_valid !== 1'b1 || dp !== DP_EN) begin
          errors++;
          $display("FAIL wrap_d0: digit=%h valid=%b dp=%b, expected 3/1/%b", digit, digit_valid, dp, DP_EN);
        end
      end
    end
    checks++;
    if (nwrap != 1) begin
      errors++;
      $display("FAIL wrap_count: pulses=%0d, expected 1", nwrap);
    end
    stream = 1'b0;
  endtask

  task automatic test_clamp();
    do_reset();
    load = 1'b1; load_data = 5'b10010;
    tick();
    load_data = 5'b11111;
    tick();
    load = 1'b0;
    checks++;
    if (rom_addr !== 10'd1010) begin
      errors++;
      $display("FAIL clamp_load: addr=%0d, expected 1010", rom_addr);
    end
    stream = 1'b1;
    tick();
    checks++;
    if (rom_addr !== 10'd0) begin
      errors++;
      $display("FAIL clamp_addr: addr=%0d, expected 0", rom_addr);
    end
    tick();
    checks++;
    if (digit !== 4'd3 || digit_valid !== 1'b1) begin
      errors++;
      $display("FAIL clamp_digit: digit=%h valid=%b, expected 3/1", digit, digit_valid);
    end
    tick();
    load = 1'b1; load_data = 5'b10101; step = 1'b1;
    repeat (3) tick();
    load = 1'b0; step = 1'b0;
    checks++;
    if (rom_addr !== 10'd1 || digit_valid !== 1'b0) begin
      errors++;
      $display("FAIL clamp_load_ignored: addr=%0d valid=%b, expected 1/0", rom_addr, digit_valid);
    end
    stream = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    stream = 1'b1;
    repeat (9) tick();
    checks++;
    if (digit !== 4'd1 || digit_valid !== 1'b1 || rom_addr !== 10'd1) begin
      errors++;
      $display("FAIL midrst_pre: digit=%h valid=%b addr=%0d, expected 1/1/1", digit, digit_valid, rom_addr);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if (digit !== 4'hF || digit_valid !== 1'b0 || rom_addr !== 10'd0 || dp !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: digit=%h valid=%b addr=%0d dp=%b, expected F/0/0/0", digit, digit_valid, rom_addr, dp);
    end
    stream = 1'b0;
    reset_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (digit_valid !== 1'b0 || rom_addr !== 10'd0) begin
      errors++;
      $display("FAIL midrst_idle: valid=%b addr=%0d, expected 0/0", digit_valid, rom_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_step();
    test_wrap();
    test_clamp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
